mssd_port_assembler: RTL and testbench

//  Downstream consumer of the MSSD serial decoder. Takes decoded nibbles (pn, p3..p0) tagged

---
 rtl/mssd_pkg.sv | 19 +
 rtl/mssd_sync_fifo.sv | 69 ++++++
 rtl/mssd_port_assembler.sv | 117 +++++++++++
 tb/tb_mssd_port_assembler.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mssd_pkg.sv
// mssd_pkg: shared types for the MSSD port assembler.
//   port_t   - 2-bit decoder port number
//   nibble_t - 4-bit decoded nibble
//   byte_t   - assembled byte
//   rec_t    - FIFO record {port, data}
package mssd_pkg;

   typedef logic [1:0] port_t;
   typedef logic [3:0] nibble_t;
   typedef logic [7:0] byte_t;

   typedef struct packed {
      port_t port;
      byte_t data;
   } rec_t;

   localparam int unsigned NUM_PORTS = 4;

endpackage

// File: rtl/mssd_sync_fifo.sv
// mssd_sync_fifo: single-clock FIFO of DEPTH entries (power of two, >= 2).
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   push_i    - write wdata_i; accepted when not full, or when full with a same-cycle pop
//   wdata_i   - record to write
//   pop_i     - remove head; ignored when empty
//   rdata_o   - head record, forced to zero while empty
//   full_o    - count_o == DEPTH
//   empty_o   - count_o == 0
//   count_o   - occupancy 0..DEPTH
module mssd_sync_fifo
   import mssd_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter type         T     = rec_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  T                       wdata_i,
   input  logic                   pop_i,
   output T                       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   T              mem_q [DEPTH];
   logic          push_en, pop_en;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = empty_o ? T'(0) : mem_q[rd_ptr_q];

   // A pop frees the slot the push needs, so a full FIFO still accepts a push alongside a pop.
   assign pop_en  = pop_i & ~empty_o;
   assign push_en = push_i & (~full_o | pop_en);

   always_comb begin
      count_d = count_q;
      unique case ({push_en, pop_en})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/mssd_port_assembler.sv
// mssd_port_assembler: pairs decoded nibbles per port into bytes and queues {port, byte} records.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   inValid    - decoder valid level; its rising edge captures one nibble
//   pn, p      - port number and nibble, sampled only on a capture
//   error      - decoder error level; its rising edge is one error event
//   outReady   - consumer accepts head record
//   outValid   - FIFO non-empty
//   outPort    - port of head record
//   outData    - byte of head record
//   pending    - bit i set while port i holds a high nibble awaiting its pair
//   overflow   - sticky, a completed byte was dropped on a full FIFO
//   errCount   - saturating error event count
//   fifoCount  - FIFO occupancy
module mssd_port_assembler
   import mssd_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned ERR_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   inValid,
   input  logic [1:0]             pn,
   input  logic [3:0]             p,
   input  logic                   error,
   input  logic                   outReady,
   output logic                   outValid,
   output logic [1:0]             outPort,
   output logic [7:0]             outData,
   output logic [3:0]             pending,
   output logic                   overflow,
   output logic [ERR_W-1:0]       errCount,
   output logic [$clog2(DEPTH):0] fifoCount
);

   logic                          in_valid_q, error_q;
   logic [NUM_PORTS-1:0]          pending_q, pending_d;
   nibble_t [NUM_PORTS-1:0]       hold_q, hold_d;
   logic                          overflow_q, overflow_d;
   logic [ERR_W-1:0]              err_cnt_q, err_cnt_d;
   logic                          cap, err_ev, push, pop_fire, full, empty;
   rec_t                          push_rec, head_rec;

   assign cap    = inValid & ~in_valid_q;
   assign err_ev = error & ~error_q;

   assign outValid = ~empty;
   assign pop_fire = outValid & outReady;

   always_comb begin
      pending_d = pending_q;
      hold_d    = hold_q;
      push      = 1'b0;
      push_rec  = '0;
      // An error event aborts every half-assembled byte, including one captured this cycle.
      if (err_ev) begin
         pending_d = '0;
      end else if (cap) begin
         if (pending_q[pn]) begin
            push          = 1'b1;
            push_rec.port = pn;
            push_rec.data = {hold_q[pn], p};
            pending_d[pn] = 1'b0;
         end else begin
            hold_d[pn]    = p;
            pending_d[pn] = 1'b1;
         end
      end
   end

   always_comb begin
      err_cnt_d  = err_cnt_q;
      if (err_ev && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_W'(1);
      overflow_d = overflow_q | (push & full & ~pop_fire);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_valid_q <= 1'b0;
         error_q    <= 1'b0;
         pending_q  <= '0;
         hold_q     <= '0;
         overflow_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         in_valid_q <= inValid;
         error_q    <= error;
         pending_q  <= pending_d;
         hold_q     <= hold_d;
         overflow_q <= overflow_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   mssd_sync_fifo #(
      .DEPTH (DEPTH),
      .T     (rec_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i (push_rec),
      .pop_i   (pop_fire),
      .rdata_o (head_rec),
      .full_o  (full),
      .empty_o (empty),
      .count_o (fifoCount)
   );

   assign outPort  = head_rec.port;
   assign outData  = head_rec.data;
   assign pending  = pending_q;
   assign overflow = overflow_q;
   assign errCount = err_cnt_q;

endmodule

// File: tb/tb_mssd_port_assembler.sv
// tb_mssd_port_assembler: scoreboard bench for mssd_port_assembler.
module tb_mssd_port_assembler;
   import mssd_pkg::*;

   localparam int DEPTH = 8;
   localparam int ERR_W = 8;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   inValid;
   logic [1:0]             pn;
   logic [3:0]             p;
   logic                   error;
   logic                   outReady;
   logic                   outValid;
   logic [1:0]             outPort;
   logic [7:0]             outData;
   logic [3:0]             pending;
   logic                   overflow;
   logic [ERR_W-1:0]       errCount;
   logic [$clog2(DEPTH):0] fifoCount;

   int   errors = 0;
   int   checks = 0;
   rec_t exp_q[$];
   rec_t mon_e;

   always #5 clk = ~clk;

   mssd_port_assembler #(
      .DEPTH (DEPTH),
      .ERR_W (ERR_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .inValid   (inValid),
      .pn        (pn),
      .p         (p),
      .error     (error),
      .outReady  (outReady),
      .outValid  (outValid),
      .outPort   (outPort),
      .outData   (outData),
      .pending   (pending),
      .overflow  (overflow),
      .errCount  (errCount),
      .fifoCount (fifoCount)
   );

   // Scoreboard: every record accepted at the coming posedge is compared with the queue head.
   always @(negedge clk) begin
      if (!rst && outValid && outReady) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rec_unexpected: got port=%0d data=%h, required no record",
                     outPort, outData);
         end else begin
            mon_e = exp_q.pop_front();
            if ({outPort, outData} !== mon_e) begin
               errors++;
               $display("FAIL rec_order: got port=%0d data=%h, required port=%0d data=%h",
                        outPort, outData, mon_e.port, mon_e.data);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_nib(input port_t prt, input nibble_t nb, input int len);
      inValid = 1'b1;
      pn      = prt;
      p       = nb;
      tick(len);
      inValid = 1'b0;
      pn      = 'x;
      p       = 'x;
      tick(1);
   endtask

   task automatic err_pulse();
      error = 1'b1;
      tick(1);
      error = 1'b0;
      tick(1);
   endtask

   task automatic wait_drain(input int maxc);
      int n = 0;
      while ((exp_q.size() != 0 || outValid) && n < maxc) begin
         tick(1);
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
      checks++;
      if ({outValid, pending, overflow} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got valid=%b pending=%b ovf=%b, required 0",
                  outValid, pending, overflow);
      end
      checks++;
      if (errCount !== '0 || fifoCount !== '0) begin
         errors++;
         $display("FAIL reset_counts: got err=%0d cnt=%0d, required 0", errCount, fifoCount);
      end
      checks++;
      if ({outPort, outData} !== 10'b0) begin
         errors++;
         $display("FAIL reset_head: got port=%0d data=%h, required 0", outPort, outData);
      end
   endtask

   task automatic test_pair();
      outReady = 1'b1;
      send_nib(2'd2, 4'hA, 4);
      checks++;
      if (pending !== 4'b0100) begin
         errors++;
         $display("FAIL pair_pending: got %b, required 0100", pending);
      end
      exp_q.push_back('{port: 2'd2, data: 8'hA5});
      send_nib(2'd2, 4'h5, 4);
      checks++;
      if (pending !== 4'b0000) begin
         errors++;
         $display("FAIL pair_pending_clr: got %b, required 0000", pending);
      end
      wait_drain(10);
      checks++;
      if (exp_q.size() != 0 || outValid) begin
         errors++;
         $display("FAIL pair_drain: got %0d left, required 0", exp_q.size());
      end
   endtask

   task automatic test_interleave();
      send_nib(2'd0, 4'h1, 2);
      send_nib(2'd3, 4'hC, 3);
      checks++;
      if (pending !== 4'b1001) begin
         errors++;
         $display("FAIL intl_pending: got %b, required 1001", pending);
      end
      exp_q.push_back('{port: 2'd0, data: 8'h12});
      send_nib(2'd0, 4'h2, 1);
      exp_q.push_back('{port: 2'd3, data: 8'hCD});
      send_nib(2'd3, 4'hD, 2);
      wait_drain(10);
      checks++;
      if (exp_q.size() != 0 || outValid) begin
         errors++;
         $display("FAIL intl_drain: got %0d left, required 0", exp_q.size());
      end
   endtask

   task automatic test_error();
      send_nib(2'd1, 4'h7, 2);
      err_pulse();
      checks++;
      if (errCount !== 8'd1 || pending !== 4'b0) begin
         errors++;
         $display("FAIL err_event: got err=%0d pending=%b, required 1 and 0000",
                  errCount, pending);
      end
      exp_q.push_back('{port: 2'd1, data: 8'h89});
      send_nib(2'd1, 4'h8, 2);
      send_nib(2'd1, 4'h9, 3);
      // Capture and error rising at the same posedge: the error wins.
      send_nib(2'd1, 4'h3, 2);
      inValid = 1'b1;
      pn      = 2'd1;
      p       = 4'h4;
      error   = 1'b1;
      tick(1);
      inValid = 1'b0;
      error   = 1'b0;
      tick(1);
      checks++;
      if (errCount !== 8'd2 || pending !== 4'b0) begin
         errors++;
         $display("FAIL err_collide: got err=%0d pending=%b, required 2 and 0000",
                  errCount, pending);
      end
      exp_q.push_back('{port: 2'd1, data: 8'h46});
      send_nib(2'd1, 4'h4, 1);
      send_nib(2'd1, 4'h6, 1);
      wait_drain(10);
      checks++;
      if (exp_q.size() != 0 || outValid) begin
         errors++;
         $display("FAIL err_drain: got %0d left, required 0", exp_q.size());
      end
   endtask

   task automatic test_overflow();
      outReady = 1'b0;
      for (int i = 0; i <= DEPTH; i++) begin
         logic [3:0] hi, lo;
         hi = 4'(i);
         lo = 4'(15 - i);
         if (i < DEPTH) exp_q.push_back('{port: 2'd0, data: {hi, lo}});
         send_nib(2'd0, hi, 1);
         send_nib(2'd0, lo, 1);
      end
      checks++;
      if (fifoCount !== 4'(DEPTH) || overflow !== 1'b1 || pending !== 4'b0) begin
         errors++;
         $display("FAIL ovf_full: got cnt=%0d ovf=%b pending=%b, required %0d 1 0000",
                  fifoCount, overflow, pending, DEPTH);
      end
      outReady = 1'b1;
      wait_drain(30);
      checks++;
      if (exp_q.size() != 0 || fifoCount !== '0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_drain: got left=%0d cnt=%0d ovf=%b, required 0 0 1",
                  exp_q.size(), fifoCount, overflow);
      end
   endtask

   task automatic test_full_pop();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL fp_rst_ovf: got %b, required 0", overflow);
      end
      outReady = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         logic [3:0] hi;
         hi = 4'(i + 3);
         exp_q.push_back('{port: 2'd2, data: {hi, 4'h6}});
         send_nib(2'd2, hi, 1);
         send_nib(2'd2, 4'h6, 1);
      end
      send_nib(2'd1, 4'hB, 1);
      exp_q.push_back('{port: 2'd1, data: 8'hBE});
      inValid  = 1'b1;
      pn       = 2'd1;
      p        = 4'hE;
      outReady = 1'b1;
      tick(1);
      inValid  = 1'b0;
      checks++;
      if (fifoCount !== 4'(DEPTH) || overflow !== 1'b0) begin
         errors++;
         $display("FAIL fp_same_cycle: got cnt=%0d ovf=%b, required %0d 0",
                  fifoCount, overflow, DEPTH);
      end
      wait_drain(30);
      checks++;
      if (exp_q.size() != 0 || fifoCount !== '0) begin
         errors++;
         $display("FAIL fp_drain: got left=%0d cnt=%0d, required 0 0", exp_q.size(), fifoCount);
      end
   endtask

   task automatic test_reset_mid();
      send_nib(2'd3, 4'hE, 2);
      checks++;
      if (pending !== 4'b1000) begin
         errors++;
         $display("FAIL rm_pending: got %b, required 1000", pending);
      end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      checks++;
      if (pending !== 4'b0000) begin
         errors++;
         $display("FAIL rm_cleared: got %b, required 0000", pending);
      end
      exp_q.push_back('{port: 2'd3, data: 8'hF1});
      send_nib(2'd3, 4'hF, 2);
      send_nib(2'd3, 4'h1, 2);
      wait_drain(10);
      checks++;
      if (exp_q.size() != 0 || outValid) begin
         errors++;
         $display("FAIL rm_drain: got %0d left, required 0", exp_q.size());
      end
   endtask

   task automatic test_err_sat();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      repeat (3) err_pulse();
      checks++;
      if (errCount !== 8'd3) begin
         errors++;
         $display("FAIL sat_three: got %0d, required 3", errCount);
      end
      repeat (257) err_pulse();
      checks++;
      if (errCount !== 8'hFF) begin
         errors++;
         $display("FAIL sat_max: got %h, required ff", errCount);
      end
   endtask

   initial begin
      rst      = 1'b1;
      inValid  = 1'b0;
      pn       = '0;
      p        = '0;
      error    = 1'b0;
      outReady = 1'b0;
      test_reset();
      test_pair();
      test_interleave();
      test_error();
      test_overflow();
      test_full_pop();
      test_reset_mid();
      test_err_sat();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
